// File: rtl/mac_tx_arbiter_pkg.sv
// Shared definitions for the MAC transmit arbiter: FSM state codes, port indices
// and the beat written to the MAC when a frame has to be terminated early.
package mac_tx_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StXfer  = 2'd1;
    localparam state_t StAbort = 2'd2;
    localparam state_t StGap   = 2'd3;

    localparam int unsigned PORT_IQ   = 0;
    localparam int unsigned PORT_CTRL = 1;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [1:0]  mod;
        logic        wren;
    } tx_beat_t;

    localparam tx_beat_t ABORT_BEAT = '{
        data: 32'h0000_0000,
        sop:  1'b0,
        eop:  1'b1,
        err:  1'b1,
        mod:  2'b00,
        wren: 1'b1
    };

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_mux.sv
// Registered 2:1 beat mux towards the MAC. Forwards the beat of the selected
// port one cycle after acceptance, or injects the abort beat.
module frame_sel_mux
    import mac_tx_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  sel,
    input  logic        inject_abort,
    input  logic [31:0] s0_data,
    input  logic        s0_sop,
    input  logic        s0_eop,
    input  logic [1:0]  s0_mod,
    input  logic [31:0] s1_data,
    input  logic        s1_sop,
    input  logic        s1_eop,
    input  logic [1:0]  s1_mod,
    output logic [31:0] tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_err,
    output logic [1:0]  tx_mod,
    output logic        tx_wren
);

    tx_beat_t beat_d;
    tx_beat_t beat_q;

    // The abort beat wins even during reset so an open frame is always closed.
    always_comb begin
        beat_d = '0;
        if (inject_abort) begin
            beat_d = ABORT_BEAT;
        end else if (reset_n) begin
            if (sel[PORT_IQ]) begin
                beat_d = '{data: s0_data, sop: s0_sop, eop: s0_eop, err: 1'b0,
                           mod: s0_mod, wren: 1'b1};
            end else if (sel[PORT_CTRL]) begin
                beat_d = '{data: s1_data, sop: s1_sop, eop: s1_eop, err: 1'b0,
                           mod: s1_mod, wren: 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        beat_q <= beat_d;
    end

    assign tx_data = beat_q.data;
    assign tx_sop  = beat_q.sop;
    assign tx_eop  = beat_q.eop;
    assign tx_err  = beat_q.err;
    assign tx_mod  = beat_q.mod;
    assign tx_wren = beat_q.wren;

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-level arbiter sharing the MAC transmit port between the IQ stream (port 0)
// and control frames (port 1), with inter-frame gap and stall abort.
module mac_tx_arbiter
    import mac_tx_arbiter_pkg::*;
#(
    parameter int unsigned IFG_CYCLES  = 16,
    parameter int unsigned CTRL_STREAK = 4,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s0_data,
    input  logic        s0_sop,
    input  logic        s0_eop,
    input  logic [1:0]  s0_mod,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [31:0] s1_data,
    input  logic        s1_sop,
    input  logic        s1_eop,
    input  logic [1:0]  s1_mod,
    input  logic        s1_valid,
    output logic        s1_ready,
    output logic [31:0] tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_err,
    output logic        tx_wren,
    output logic [1:0]  tx_mod,
    input  logic        tx_rdy,
    input  logic        tx_a_full,
    output logic [1:0]  grant,
    output logic [15:0] abort_count,
    output logic [15:0] drop_count
);

    localparam logic [15:0] IfgInit   = 16'(IFG_CYCLES);
    localparam logic [15:0] StallLast = 16'(STALL_LIMIT - 1);
    localparam logic [7:0]  StreakMax = 8'(CTRL_STREAK);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  streak_q, streak_d;
    logic [15:0] abort_cnt_q, abort_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic       tx_ok;
    logic       s0_req;
    logic       s1_req;
    logic       gnt_valid;
    logic [1:0] fwd;
    logic       inject_abort;
    logic       mux_abort;

    assign tx_ok     = tx_rdy & ~tx_a_full;
    assign s0_req    = s0_valid & s0_sop;
    assign s1_req    = s1_valid & s1_sop;
    assign gnt_valid = (grant_q[PORT_IQ] & s0_valid) | (grant_q[PORT_CTRL] & s1_valid);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        streak_d     = streak_q;
        abort_cnt_d  = abort_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        fwd          = 2'b00;
        inject_abort = 1'b0;

        case (state_q)
            StIdle: begin
                // Port 1 is examined first, both for drops and for new frames.
                if (s1_valid && !s1_sop) begin
                    s1_ready   = 1'b1;
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end else if (s1_req && tx_ok && (streak_q < StreakMax || !s0_req)) begin
                    s1_ready = 1'b1;
                    fwd      = 2'b10;
                    grant_d  = 2'b10;
                    streak_d = (streak_q < StreakMax) ? streak_q + 8'd1 : streak_q;
                    state_d  = s1_eop ? StGap : StXfer;
                    cnt_d    = s1_eop ? IfgInit : 16'd0;
                end else if (s0_valid && !s0_sop) begin
                    s0_ready   = 1'b1;
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end else if (s0_req && tx_ok) begin
                    s0_ready = 1'b1;
                    fwd      = 2'b01;
                    grant_d  = 2'b01;
                    streak_d = 8'd0;
                    state_d  = s0_eop ? StGap : StXfer;
                    cnt_d    = s0_eop ? IfgInit : 16'd0;
                end
            end

            StXfer: begin
                s0_ready = grant_q[PORT_IQ] & tx_ok;
                s1_ready = grant_q[PORT_CTRL] & tx_ok;
                fwd      = {s1_valid & s1_ready, s0_valid & s0_ready};
                if (fwd != 2'b00) begin
                    if ((fwd[PORT_IQ] && s0_eop) || (fwd[PORT_CTRL] && s1_eop)) begin
                        state_d = StGap;
                        cnt_d   = IfgInit;
                    end else begin
                        cnt_d = 16'd0;
                    end
                end else if (!gnt_valid && tx_ok) begin
                    // Stall cycles are only counted while the MAC could have taken a beat.
                    if (cnt_q >= StallLast) begin
                        state_d      = StAbort;
                        inject_abort = 1'b1;
                        abort_cnt_d  = sat_inc(abort_cnt_q);
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            StAbort: begin
                grant_d = 2'b00;
                state_d = StGap;
                cnt_d   = IfgInit;
            end

            StGap: begin
                grant_d = 2'b00;
                if (cnt_q <= 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    // A reset that lands inside an open frame still closes it on the MAC side.
    assign mux_abort = reset_n ? inject_abort : (state_q == StXfer);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            grant_q     <= 2'b00;
            cnt_q       <= 16'd0;
            streak_q    <= 8'd0;
            abort_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            abort_cnt_q <= abort_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    frame_sel_mux u_mux (
        .clk          (clk),
        .reset_n      (reset_n),
        .sel          (fwd),
        .inject_abort (mux_abort),
        .s0_data      (s0_data),
        .s0_sop       (s0_sop),
        .s0_eop       (s0_eop),
        .s0_mod       (s0_mod),
        .s1_data      (s1_data),
        .s1_sop       (s1_sop),
        .s1_eop       (s1_eop),
        .s1_mod       (s1_mod),
        .tx_data      (tx_data),
        .tx_sop       (tx_sop),
        .tx_eop       (tx_eop),
        .tx_err       (tx_err),
        .tx_mod       (tx_mod),
        .tx_wren      (tx_wren)
    );

    assign grant       = grant_q;
    assign abort_count = abort_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter: handshake-driven sources push expected
// MAC writes into a scoreboard that a negedge monitor pops and compares.
module tb_mac_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s0_data, s1_data;
    logic        s0_sop, s0_eop, s0_valid, s0_ready;
    logic        s1_sop, s1_eop, s1_valid, s1_ready;
    logic [1:0]  s0_mod, s1_mod;
    logic [31:0] tx_data;
    logic        tx_sop, tx_eop, tx_err, tx_wren;
    logic [1:0]  tx_mod;
    logic        tx_rdy, tx_a_full;
    logic [1:0]  grant;
    logic [15:0] abort_count, drop_count;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [1:0]  mod;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
    } exp_t;

    typedef struct {
        int port;
        int fid;
        int cyc;
    } sop_rec_t;

    exp_t     sb[$];
    sop_rec_t sop_log[$];
    int       eop_log[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    bit       grant_chk = 1'b0;

    mac_tx_arbiter #(
        .IFG_CYCLES  (16),
        .CTRL_STREAK (4),
        .STALL_LIMIT (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s0_data     (s0_data),
        .s0_sop      (s0_sop),
        .s0_eop      (s0_eop),
        .s0_mod      (s0_mod),
        .s0_valid    (s0_valid),
        .s0_ready    (s0_ready),
        .s1_data     (s1_data),
        .s1_sop      (s1_sop),
        .s1_eop      (s1_eop),
        .s1_mod      (s1_mod),
        .s1_valid    (s1_valid),
        .s1_ready    (s1_ready),
        .tx_data     (tx_data),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_err      (tx_err),
        .tx_wren     (tx_wren),
        .tx_mod      (tx_mod),
        .tx_rdy      (tx_rdy),
        .tx_a_full   (tx_a_full),
        .grant       (grant),
        .abort_count (abort_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every MAC write must match the head of the scoreboard, including its cycle.
    initial begin
        beat_t act;
        exp_t  e;
        forever begin
            @(negedge clk);
            if (grant_chk) begin
                checks++;
                if (grant !== 2'b00) begin
                    errors++;
                    $display("FAIL grant_release: grant=%b required 00 (cycle %0d)", grant, cyc);
                end
                grant_chk = 1'b0;
            end
            if (tx_wren === 1'b1) begin
                act = {tx_data, tx_sop, tx_eop, tx_err, tx_mod};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h at cycle %0d, none required", act, cyc);
                end else begin
                    e = sb.pop_front();
                    if (act !== e.b || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL beat: got %h at cycle %0d, required %h at cycle %0d",
                                 act, cyc, e.b, e.cyc);
                    end
                end
                if (tx_sop === 1'b1) begin
                    sop_log.push_back('{int'(tx_data[31:28]), int'(tx_data[27:20]), cyc});
                    checks++;
                    if (grant !== ((tx_data[31:28] == 4'd1) ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL grant_at_sop: grant=%b for port %0d", grant,
                                 tx_data[31:28]);
                    end
                end
                if (tx_eop === 1'b1) begin
                    eop_log.push_back(cyc);
                    grant_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input int port, input int fid, input int i);
        return {port[3:0], fid[7:0], i[19:0]};
    endfunction

    task automatic drive_port(input int port, input logic [31:0] d, input logic sop,
                              input logic eop, input logic [1:0] mod, input logic v);
        if (port == 0) begin
            s0_data = d; s0_sop = sop; s0_eop = eop; s0_mod = mod; s0_valid = v;
        end else begin
            s1_data = d; s1_sop = sop; s1_eop = eop; s1_mod = mod; s1_valid = v;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_beat(input int port, input logic [31:0] d, input logic sop,
                             input logic eop, input logic [1:0] mod, input bit expect_wr,
                             output int acc_cyc);
        bit   ok = 1'b0;
        int   guard = 0;
        exp_t e;
        acc_cyc = -1;
        drive_port(port, d, sop, eop, mod, 1'b1);
        while (!ok && guard < 4000) begin
            #4;
            if (((port == 0) ? s0_ready : s1_ready) === 1'b1) begin
                ok      = 1'b1;
                acc_cyc = cyc + 1;
                if (expect_wr) begin
                    e.b   = {d, sop, eop, 1'b0, mod};
                    e.cyc = cyc + 1;
                    sb.push_back(e);
                end
            end
            @(negedge clk);
            guard++;
        end
        drive_port(port, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: port %0d beat %h accepted=0 required 1", port, d);
        end
    endtask

    task automatic send_frame(input int port, input int fid, input int len);
        int acc;
        for (int i = 0; i < len; i++) begin
            send_beat(port, mk(port, fid, i), i == 0, i == len - 1,
                      (i == len - 1) ? 2'(fid % 4) : 2'b00, 1'b1, acc);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sop_log.delete();
        eop_log.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({tx_wren, tx_sop, tx_eop, tx_err} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_flags: wren/sop/eop/err=%b required 0000", tag,
                     {tx_wren, tx_sop, tx_eop, tx_err});
        end
        checks++;
        if (tx_data !== 32'h0 || tx_mod !== 2'b00) begin
            errors++;
            $display("FAIL %s_data: data=%h mod=%b required 0", tag, tx_data, tx_mod);
        end
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL %s_grant: grant=%b required 00", tag, grant);
        end
        checks++;
        if (abort_count !== 16'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL %s_counts: abort=%0d drop=%0d required 0/0", tag, abort_count,
                     drop_count);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready=%b%b required 00", s1_ready, s0_ready);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_single_frame();
        do_reset();
        send_frame(0, 1, 380);
        send_frame(0, 2, 4);
        wait_drain();
        checks++;
        if (sop_log.size() != 2 || eop_log.size() != 2) begin
            errors++;
            $display("FAIL single_frames: sops=%0d eops=%0d required 2/2", sop_log.size(),
                     eop_log.size());
        end else begin
            checks++;
            if (eop_log[0] - sop_log[0].cyc != 379) begin
                errors++;
                $display("FAIL single_span: %0d required 379", eop_log[0] - sop_log[0].cyc);
            end
            checks++;
            if (sop_log[1].cyc - eop_log[0] != 17) begin
                errors++;
                $display("FAIL single_ifg: %0d required 17", sop_log[1].cyc - eop_log[0]);
            end
        end
    endtask

    task automatic test_both_sop();
        do_reset();
        fork
            send_frame(1, 10, 8);
            send_frame(0, 11, 8);
        join
        wait_drain();
        checks++;
        if (sop_log.size() != 2 || eop_log.size() != 2) begin
            errors++;
            $display("FAIL both_frames: sops=%0d required 2", sop_log.size());
        end else begin
            checks++;
            if (sop_log[0].port != 1 || sop_log[1].port != 0) begin
                errors++;
                $display("FAIL both_order: %0d,%0d required 1,0", sop_log[0].port,
                         sop_log[1].port);
            end
            checks++;
            if (sop_log[1].cyc - eop_log[0] != 17) begin
                errors++;
                $display("FAIL both_ifg: %0d required 17", sop_log[1].cyc - eop_log[0]);
            end
        end
    endtask

    task automatic test_streak();
        int exp_order[7];
        exp_order = '{1, 1, 1, 1, 0, 1, 1};
        do_reset();
        fork
            send_frame(0, 20, 3);
            begin
                for (int k = 0; k < 6; k++) send_frame(1, 30 + k, 3);
            end
        join
        wait_drain();
        checks++;
        if (sop_log.size() != 7) begin
            errors++;
            $display("FAIL streak_frames: %0d required 7", sop_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (sop_log[i].port != exp_order[i]) begin
                    errors++;
                    $display("FAIL streak_order[%0d]: port %0d required %0d", i,
                             sop_log[i].port, exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_stall_abort();
        int   acc;
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(0, mk(0, 40, i), i == 0, 1'b0, 2'b00, 1'b1, acc);
        repeat (63) @(negedge clk);
        for (int i = 3; i < 5; i++) send_beat(0, mk(0, 40, i), 1'b0, 1'b0, 2'b00, 1'b1, acc);
        e.b   = {32'h0, 1'b0, 1'b1, 1'b1, 2'b00};
        e.cyc = acc + 64;
        sb.push_back(e);
        repeat (64) @(negedge clk);
        for (int i = 5; i < 20; i++) begin
            send_beat(0, mk(0, 40, i), 1'b0, i == 19, 2'b00, 1'b0, acc);
        end
        wait_drain();
        checks++;
        if (abort_count !== 16'd1) begin
            errors++;
            $display("FAIL stall_abort_count: %0d required 1", abort_count);
        end
        checks++;
        if (drop_count !== 16'd15) begin
            errors++;
            $display("FAIL stall_drop_count: %0d required 15", drop_count);
        end
        checks++;
        if (eop_log.size() != 1) begin
            errors++;
            $display("FAIL stall_eops: %0d required 1", eop_log.size());
        end
    endtask

    task automatic test_afull();
        bit done = 1'b0;
        do_reset();
        fork
            begin
                send_frame(0, 50, 30);
                done = 1'b1;
            end
            begin
                int n = 0;
                while (!done && n < 500) begin
                    @(negedge clk);
                    tx_a_full = ~tx_a_full;
                    #4;
                    if (tx_a_full && !done) begin
                        checks++;
                        if (s0_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL afull_ready: ready=%b required 0", s0_ready);
                        end
                    end
                    n++;
                end
                tx_a_full = 1'b0;
            end
        join
        wait_drain();
        checks++;
        if (sop_log.size() != 1 || eop_log.size() != 1) begin
            errors++;
            $display("FAIL afull_frames: sops=%0d eops=%0d required 1/1", sop_log.size(),
                     eop_log.size());
        end else begin
            checks++;
            if (eop_log[0] - sop_log[0].cyc <= 29) begin
                errors++;
                $display("FAIL afull_span: %0d required > 29", eop_log[0] - sop_log[0].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int   acc;
        exp_t e;
        do_reset();
        for (int i = 0; i < 10; i++) send_beat(0, mk(0, 60, i), i == 0, 1'b0, 2'b00, 1'b1, acc);
        reset_n = 1'b0;
        e.b   = {32'h0, 1'b0, 1'b1, 1'b1, 2'b00};
        e.cyc = acc + 1;
        sb.push_back(e);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        sop_log.delete();
        eop_log.delete();
        send_frame(0, 61, 5);
        wait_drain();
        checks++;
        if (sop_log.size() != 1 || eop_log.size() != 1) begin
            errors++;
            $display("FAIL mid_reset_new_frame: sops=%0d required 1", sop_log.size());
        end
        checks++;
        if (abort_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_abort_count: %0d required 0", abort_count);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        tx_rdy    = 1'b1;
        tx_a_full = 1'b0;
        drive_port(0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        drive_port(1, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        test_reset();
        test_single_frame();
        test_both_sop();
        test_streak();
        test_stall_abort();
        test_afull();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Frame-level arbiter sharing the single Ethernet MAC transmit port between the IQ packetizer stream (port 0) and the control/status frame source (port 1). It grants whole frames only, so frames never interleave. It inserts a fixed inter-frame idle gap and aborts frames whose source stalls mid-frame. It sits between both frame sources and the MAC, on the MAC transmit clock domain.

## Interface
- IFG_CYCLES, 16: idle cycles enforced after every eop before the next grant (≥1).
- CTRL_STREAK, 4: maximum consecutive port-1 frames while port 0 has a pending sop.
- STALL_LIMIT, 64: consecutive granted cycles with src_valid=0 before the frame is aborted (≥2).
- clk  in  1  MAC transmit clock.
- reset_n  in  1  synchronous, active-low.
- s0_data, s1_data  in  32  source beat data, first byte in [31:24].
- s0_sop/s0_eop, s1_sop/s1_eop  in  1  frame delimiters.
- s0_mod, s1_mod  in  2  empty-byte count, valid with eop only.
- s0_valid, s1_valid  in  1  beat present.
- s0_ready, s1_ready  out  1  beat accepted this cycle when valid&ready.
- tx_data  out  32, tx_sop/tx_eop/tx_err/tx_wren  out  1, tx_mod  out  2  to MAC.
- tx_rdy, tx_a_full  in  1  MAC backpressure.
- grant  out  2  one-hot current owner, 00 when idle.
- abort_count  out  16  saturating count of aborted frames.
- drop_count  out  16  saturating count of discarded non-sop beats in IDLE.

## Operation
- States: IDLE, XFER, ABORT, GAP.
- IDLE: if s1_valid&s1_sop and (streak<CTRL_STREAK or no s0 sop pending), grant port 1, streak+1; else if s0_valid&s0_sop, grant port 0, streak cleared; → XFER. Grant decided combinationally; the first beat is accepted in the same cycle.
- IDLE, valid without sop on a port: beat consumed (ready=1), discarded, drop_count+1. Port 1 takes precedence for this as well.
- XFER: sN_ready = grant[N] & tx_rdy & ~tx_a_full. Ungranted ready=0. An accepted eop beat → GAP with counter=IFG_CYCLES.
- XFER stall: counter increments when the granted port has valid=0, and clears on any accepted beat. Backpressure cycles are not counted. At STALL_LIMIT → ABORT.
- ABORT: one cycle of tx_wren=1, tx_eop=1, tx_err=1, tx_data=0, tx_mod=0. abort_count+1, grant cleared, → GAP. Later beats from the stalled source are handled as non-sop drops.
- GAP: counter decrements to 0 → IDLE. All readies 0.
- An sop arriving mid-frame on the granted port is forwarded unchanged. Frame-format checking is the MAC's job.
- Counters saturate at 0xFFFF.

## Timing
- Accepted beat appears on tx_* with tx_wren=1 exactly one cycle later (registered outputs). tx_wren=0 on all other cycles.
- Idle bus between frames is IFG_CYCLES+1 cycles minimum (eop write → next sop write).
- grant updates in the cycle after the arbitration decision. It returns to 00 the cycle after the eop write.
- Reset with no frame open: all outputs 0, state IDLE, streak/counters 0.
- Reset while a frame is open (sop written, eop not): the next cycle emits one abort beat (tx_wren=tx_eop=tx_err=1). Then all outputs are 0. abort_count is cleared, not incremented.
- tx_rdy falling with a beat already accepted: that beat still writes next cycle. The MAC tolerates one beat after deassert.

## Structure
- Shared package: state enum, port index constants (PORT_IQ=0, PORT_CTRL=1), abort beat constant.
- Sub-module: frame_sel_mux (2:1 registered beat mux, gated by grant), reused by later sources.

## Test plan
- Single 380-word frame on port 0, tx_rdy=1 → 380 writes, sop on the first, eop+mod on the last, then 16 idle cycles.
- Both ports raise sop in the same cycle → port 1 frame first. Port 0 frame starts 17 cycles after the port-1 eop write.
- Port 1 streams 6 back-to-back frames while port 0 is pending, CTRL_STREAK=4 → order 1,1,1,1,0,1,1.
- Port 0 drops valid for 64 cycles mid-frame → abort beat with eop=err=1, abort_count=1. Remaining beats are counted in drop_count.
- tx_a_full toggling every other cycle during a frame → no beat lost or duplicated, and the data sequence is intact.
- Reset pulse at word 10 of a frame → one abort beat, then outputs 0. A new frame is accepted after reset releases.
